hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard and stall controller for the 5-stage MIPS core (IF, ID, EX, MEM/WB with branches resolved in ID). It replaces the single-cycle stall/flush logic with a sequenced controller that covers four cases: load-use and branch-operand interlocks, a multi-cycle multiply/divide unit (MDU) with a busy countdown, data-memory wait states with a timeout, and optional branch delay slots. It drives per-stage stall and flush lines to pc, if_id, id_ex and ex_mem, and keeps a saturating stall-cycle counter.

## Interface
- REG_ADDR_W, 5, register address width
- MDU_CYCLES, 8, MDU busy duration in cycles (>=2)
- MEM_TIMEOUT, 16, frozen cycles before a memory access is abandoned (>=1)
- DELAY_SLOT, 0, 1 = no IF/ID flush on taken branch
- COUNT_W, 16, stall counter width

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs, id_rt  in  REG_ADDR_W  ID source registers
- id_rs_used, id_rt_used  in  1  ID actually reads rs/rt
- id_branch  in  1  ID instruction needs operands in ID (branch, jr)
- id_mdu  in  1  ID instruction uses MDU (mult/div/mfhi/mflo)
- branch_taken  in  1  ID resolved taken branch/jump
- ex_wreg  in  REG_ADDR_W, ex_RegWrite, ex_MemRead  in  1  EX destination info
- mem_wreg  in  REG_ADDR_W, mem_RegWrite, mem_MemRead  in  1  MEM destination info
- mdu_start  in  1  EX instruction launches an MDU op
- dmem_req, dmem_ready  in  1  data memory request/ready
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1  hold stage register
- flush_if_id, flush_id_ex, flush_ex_mem  out  1  bubble stage register
- mdu_busy, mdu_done  out  1  MDU status
- mem_err  out  1  one-cycle pulse when an access times out
- stall_count  out  COUNT_W  saturating count of cycles with stall_pc=1

## Operation
- Match condition: a register matches only if it is nonzero and equal; register 0 never matches.
- Data bubble (DB). DB is asserted when any of the following holds:
  - ex_MemRead & ex_RegWrite and ex_wreg matches a used ID source (load-use).
  - id_branch & ex_RegWrite and ex_wreg matches a used source.
  - id_branch & mem_MemRead & mem_RegWrite and mem_wreg matches a used source.
  - id_mdu & mdu_busy.
- DB action: stall_pc=1, stall_if_id=1, flush_id_ex=1.
- MDU FSM (IDLE, BUSY):
  - IDLE→BUSY on mdu_start; counter is loaded with MDU_CYCLES-1.
  - BUSY decrements every cycle, including while frozen. At 0 it asserts mdu_done and returns to IDLE.
  - mdu_start in BUSY is ignored; DB is what prevents it.
- Memory FSM (RUN, WAIT, ERR):
  - Freeze (FZ) = dmem_req & ~dmem_ready in RUN or WAIT.
  - FZ drives all four stall lines to 1 and all flushes to 0.
  - RUN→WAIT on FZ, with wait_cnt=1. WAIT increments wait_cnt per frozen cycle. wait_cnt clears and the FSM returns to RUN when dmem_ready or ~dmem_req.
  - When wait_cnt==MEM_TIMEOUT and still FZ, the FSM enters ERR. The ERR cycle gives mem_err=1, no freeze, flush_ex_mem=1 (access dropped), then RUN.
- Taken branch: when branch_taken & ~DB & ~FZ & DELAY_SLOT==0, flush_if_id=1.
- Priority: FZ > DB > branch flush. Under FZ, DB and the branch flush are suppressed and re-evaluate after release.
- stall_count increments when stall_pc=1 and saturates at all-ones.

## Timing
- Stall/flush outputs are combinational from current inputs and FSM state; there is no added latency.
- mdu_start sampled at edge k gives mdu_busy=1 for cycles k+1 … k+MDU_CYCLES. mdu_done=1 only in the last busy cycle.
- FZ begins in the same cycle dmem_ready falls with dmem_req high. It releases in the same cycle dmem_ready rises.
- Timeout: freeze lasts exactly MEM_TIMEOUT cycles, then comes one ERR cycle.
- Reset, including mid-operation:
  - Both FSMs go to IDLE/RUN; wait_cnt, MDU counter and stall_count are cleared.
  - While rst is high, every output is 0.
- Simultaneous events:
  - mdu_start under FZ is accepted.
  - A DB and a taken branch in the same cycle give DB only; the branch is re-resolved next cycle.

## Test plan
- lw $1 in EX (ex_MemRead=1, ex_wreg=1), ID add reads rs=1 → exactly one cycle of stall_pc=stall_if_id=flush_id_ex=1, stall_count=1. Same case with ex_wreg=0 → no stall.
- beq in ID with rs=3, EX addi writing $3 → one bubble. Next cycle, mem_MemRead writing $3 → second bubble. Then branch_taken → flush_if_id=1 (and 0 when DELAY_SLOT=1).
- mdu_start pulse, MDU_CYCLES=8:
  - mdu_busy high 8 cycles, mdu_done on the 8th.
  - id_mdu=1 throughout gives 8 bubbles; the bubble releases once mdu_busy drops.
- dmem_req=1, dmem_ready low 3 cycles → all stalls 1 for 3 cycles, no flushes, no mem_err. Concurrent load-use is suppressed, then bubbles once after release.
- dmem_ready held low, MEM_TIMEOUT=16 → 16 frozen cycles, then mem_err=1 with flush_ex_mem=1 for 1 cycle, then RUN.
- rst asserted mid MDU BUSY and mid WAIT → next cycle mdu_busy=0, all outputs 0, stall_count=0. 300 consecutive stall cycles with COUNT_W=8 → stall_count saturates at 255.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Signal bundle between the MIPS pipeline and hazard_ctrl.
//               The pipeline side (master) drives ID/EX/MEM stage information
//               and the data-memory handshake; the controller side (slave)
//               returns per-stage stall/flush lines and status.
// Ports       : id_rs/id_rt/*_used, id_branch, id_mdu, branch_taken  (ID)
//               ex_wreg/ex_RegWrite/ex_MemRead                       (EX)
//               mem_wreg/mem_RegWrite/mem_MemRead                    (MEM)
//               mdu_start, dmem_req, dmem_ready                      (events)
//               stall_*, flush_*, mdu_busy, mdu_done, mem_err,
//               stall_count                                          (results)
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int COUNT_W    = 16
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic                  id_branch;
    logic                  id_mdu;
    logic                  branch_taken;
    logic [REG_ADDR_W-1:0] ex_wreg;
    logic                  ex_RegWrite;
    logic                  ex_MemRead;
    logic [REG_ADDR_W-1:0] mem_wreg;
    logic                  mem_RegWrite;
    logic                  mem_MemRead;
    logic                  mdu_start;
    logic                  dmem_req;
    logic                  dmem_ready;
    logic                  stall_pc;
    logic                  stall_if_id;
    logic                  stall_id_ex;
    logic                  stall_ex_mem;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic                  flush_ex_mem;
    logic                  mdu_busy;
    logic                  mdu_done;
    logic                  mem_err;
    logic [COUNT_W-1:0]    stall_count;

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, id_branch, id_mdu,
               branch_taken, ex_wreg, ex_RegWrite, ex_MemRead, mem_wreg,
               mem_RegWrite, mem_MemRead, mdu_start, dmem_req, dmem_ready,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
               flush_id_ex, flush_ex_mem, mdu_busy, mdu_done, mem_err,
               stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_branch, id_mdu,
               branch_taken, ex_wreg, ex_RegWrite, ex_MemRead, mem_wreg,
               mem_RegWrite, mem_MemRead, mdu_start, dmem_req, dmem_ready,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
               flush_id_ex, flush_ex_mem, mdu_busy, mdu_done, mem_err,
               stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard and stall controller for the 5-stage MIPS
//               core. Handles load-use / branch-operand interlocks (data
//               bubble), a multi-cycle MDU busy countdown, data-memory wait
//               states with timeout, and optional branch delay slots.
//               All stall/flush lines are combinational from the current
//               inputs and FSM state. Priority: freeze > bubble > branch.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               bus (slave)      - stage info in, stall/flush/status out
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_CYCLES  = 8,
    parameter int MEM_TIMEOUT = 16,
    parameter int DELAY_SLOT  = 0,
    parameter int COUNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave bus
);
    localparam int c_MDU_W  = $clog2(MDU_CYCLES);
    localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam bit c_BR_FLUSH_EN = (DELAY_SLOT == 0);

    localparam logic [0:0] c_MDU_IDLE = 1'b0;
    localparam logic [0:0] c_MDU_BUSY = 1'b1;

    localparam logic [1:0] c_MEM_RUN  = 2'd0;
    localparam logic [1:0] c_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_MEM_ERR  = 2'd2;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic f_match(input logic [REG_ADDR_W-1:0] a,
                                     input logic [REG_ADDR_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // ------------------------------------------------------------------
    // MDU busy FSM
    // ------------------------------------------------------------------
    logic [0:0]         r_mdu_state;
    logic [0:0]         w_mdu_state_nxt;
    logic [c_MDU_W-1:0] r_mdu_cnt;
    logic [c_MDU_W-1:0] w_mdu_cnt_nxt;
    logic               w_mdu_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mdu_state <= c_MDU_IDLE;
            r_mdu_cnt   <= '0;
        end else begin
            r_mdu_state <= w_mdu_state_nxt;
            r_mdu_cnt   <= w_mdu_cnt_nxt;
        end
    end

    // Counts down unconditionally, even while the pipeline is frozen; a
    // start request during BUSY is ignored (the bubble keeps it out of EX).
    always_comb begin
        w_mdu_state_nxt = r_mdu_state;
        w_mdu_cnt_nxt   = r_mdu_cnt;
        case (r_mdu_state)
            c_MDU_IDLE: begin
                if (bus.mdu_start) begin
                    w_mdu_state_nxt = c_MDU_BUSY;
                    w_mdu_cnt_nxt   = c_MDU_W'(MDU_CYCLES - 1);
                end
            end
            c_MDU_BUSY: begin
                if (r_mdu_cnt == '0) begin
                    w_mdu_state_nxt = c_MDU_IDLE;
                end else begin
                    w_mdu_cnt_nxt = r_mdu_cnt - c_MDU_W'(1);
                end
            end
            default: begin
                w_mdu_state_nxt = c_MDU_IDLE;
                w_mdu_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_mdu_busy = (r_mdu_state == c_MDU_BUSY);

    always_comb begin
        bus.mdu_busy = 1'b0;
        bus.mdu_done = 1'b0;
        if (!rst) begin
            bus.mdu_busy = w_mdu_busy;
            bus.mdu_done = w_mdu_busy && (r_mdu_cnt == '0);
        end
    end

    // ------------------------------------------------------------------
    // Data-memory wait FSM
    // ------------------------------------------------------------------
    logic [1:0]          r_mem_state;
    logic [1:0]          w_mem_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_cnt_nxt;
    logic [c_WAIT_W-1:0] w_wait_inc;
    logic                w_fz;

    assign w_fz = bus.dmem_req && !bus.dmem_ready &&
                  ((r_mem_state == c_MEM_RUN) || (r_mem_state == c_MEM_WAIT));
    // r_wait_cnt holds frozen cycles already completed; w_wait_inc includes
    // the current one, so the freeze lasts exactly MEM_TIMEOUT cycles.
    assign w_wait_inc = r_wait_cnt + c_WAIT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_state <= c_MEM_RUN;
            r_wait_cnt  <= '0;
        end else begin
            r_mem_state <= w_mem_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_mem_state_nxt = c_MEM_RUN;
        w_wait_cnt_nxt  = '0;
        case (r_mem_state)
            c_MEM_RUN, c_MEM_WAIT: begin
                if (w_fz) begin
                    if (w_wait_inc == c_WAIT_W'(MEM_TIMEOUT)) begin
                        w_mem_state_nxt = c_MEM_ERR;
                    end else begin
                        w_mem_state_nxt = c_MEM_WAIT;
                        w_wait_cnt_nxt  = w_wait_inc;
                    end
                end
            end
            default: begin
                w_mem_state_nxt = c_MEM_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard detection and stall/flush outputs
    // ------------------------------------------------------------------
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_db_raw;
    logic w_db;
    logic w_br_flush;
    logic w_stall_pc;

    assign w_ex_hit  = (bus.id_rs_used && f_match(bus.ex_wreg, bus.id_rs)) ||
                       (bus.id_rt_used && f_match(bus.ex_wreg, bus.id_rt));
    assign w_mem_hit = (bus.id_rs_used && f_match(bus.mem_wreg, bus.id_rs)) ||
                       (bus.id_rt_used && f_match(bus.mem_wreg, bus.id_rt));

    assign w_db_raw = (bus.ex_MemRead && bus.ex_RegWrite && w_ex_hit) ||
                      (bus.id_branch && bus.ex_RegWrite && w_ex_hit) ||
                      (bus.id_branch && bus.mem_MemRead && bus.mem_RegWrite &&
                       w_mem_hit) ||
                      (bus.id_mdu && w_mdu_busy);

    // A bubble holds the branch in ID, so it is re-resolved next cycle
    // rather than flushing IF/ID now.
    assign w_db       = w_db_raw && !w_fz;
    assign w_br_flush = c_BR_FLUSH_EN && bus.branch_taken && !w_db_raw && !w_fz;
    assign w_stall_pc = w_fz || w_db;

    always_comb begin
        bus.stall_pc     = 1'b0;
        bus.stall_if_id  = 1'b0;
        bus.stall_id_ex  = 1'b0;
        bus.stall_ex_mem = 1'b0;
        bus.flush_if_id  = 1'b0;
        bus.flush_id_ex  = 1'b0;
        bus.flush_ex_mem = 1'b0;
        bus.mem_err      = 1'b0;
        if (!rst) begin
            bus.stall_pc     = w_stall_pc;
            bus.stall_if_id  = w_stall_pc;
            bus.stall_id_ex  = w_fz;
            bus.stall_ex_mem = w_fz;
            bus.flush_if_id  = w_br_flush;
            bus.flush_id_ex  = w_db;
            // The abandoned access is dropped by bubbling EX/MEM.
            bus.flush_ex_mem = (r_mem_state == c_MEM_ERR);
            bus.mem_err      = (r_mem_state == c_MEM_ERR);
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    logic [COUNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_pc && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + COUNT_W'(1);
        end
    end

    assign bus.stall_count = rst ? '0 : r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed testbench for hazard_ctrl. Two instances share the
//               same stimulus: u_dut1 with default parameters, u_dut2 with
//               DELAY_SLOT=1 and an 8-bit stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
    logic id_rs_used, id_rt_used, id_branch, id_mdu, branch_taken;
    logic ex_RegWrite, ex_MemRead, mem_RegWrite, mem_MemRead;
    logic mdu_start, dmem_req, dmem_ready;

    hazard_ctrl_if #(.REG_ADDR_W(5), .COUNT_W(16)) u_if1 ();
    hazard_ctrl_if #(.REG_ADDR_W(5), .COUNT_W(8))  u_if2 ();

    assign u_if1.id_rs = id_rs;               assign u_if2.id_rs = id_rs;
    assign u_if1.id_rt = id_rt;               assign u_if2.id_rt = id_rt;
    assign u_if1.id_rs_used = id_rs_used;     assign u_if2.id_rs_used = id_rs_used;
    assign u_if1.id_rt_used = id_rt_used;     assign u_if2.id_rt_used = id_rt_used;
    assign u_if1.id_branch = id_branch;       assign u_if2.id_branch = id_branch;
    assign u_if1.id_mdu = id_mdu;             assign u_if2.id_mdu = id_mdu;
    assign u_if1.branch_taken = branch_taken; assign u_if2.branch_taken = branch_taken;
    assign u_if1.ex_wreg = ex_wreg;           assign u_if2.ex_wreg = ex_wreg;
    assign u_if1.ex_RegWrite = ex_RegWrite;   assign u_if2.ex_RegWrite = ex_RegWrite;
    assign u_if1.ex_MemRead = ex_MemRead;     assign u_if2.ex_MemRead = ex_MemRead;
    assign u_if1.mem_wreg = mem_wreg;         assign u_if2.mem_wreg = mem_wreg;
    assign u_if1.mem_RegWrite = mem_RegWrite; assign u_if2.mem_RegWrite = mem_RegWrite;
    assign u_if1.mem_MemRead = mem_MemRead;   assign u_if2.mem_MemRead = mem_MemRead;
    assign u_if1.mdu_start = mdu_start;       assign u_if2.mdu_start = mdu_start;
    assign u_if1.dmem_req = dmem_req;         assign u_if2.dmem_req = dmem_req;
    assign u_if1.dmem_ready = dmem_ready;     assign u_if2.dmem_ready = dmem_ready;

    hazard_ctrl #(
        .REG_ADDR_W(5), .MDU_CYCLES(8), .MEM_TIMEOUT(16),
        .DELAY_SLOT(0), .COUNT_W(16)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));

    hazard_ctrl #(
        .REG_ADDR_W(5), .MDU_CYCLES(8), .MEM_TIMEOUT(16),
        .DELAY_SLOT(1), .COUNT_W(8)
    ) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2));

    // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
    //  flush_if_id, flush_id_ex, flush_ex_mem}
    localparam logic [6:0] c_NONE = 7'b0000000;
    localparam logic [6:0] c_DB   = 7'b1100010;
    localparam logic [6:0] c_FZ   = 7'b1111000;
    localparam logic [6:0] c_BR   = 7'b0000100;
    localparam logic [6:0] c_ERR  = 7'b0000001;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] outs1();
        return {u_if1.stall_pc, u_if1.stall_if_id, u_if1.stall_id_ex,
                u_if1.stall_ex_mem, u_if1.flush_if_id, u_if1.flush_id_ex,
                u_if1.flush_ex_mem};
    endfunction

    function automatic logic [6:0] outs2();
        return {u_if2.stall_pc, u_if2.stall_if_id, u_if2.stall_id_ex,
                u_if2.stall_ex_mem, u_if2.flush_if_id, u_if2.flush_id_ex,
                u_if2.flush_ex_mem};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = '0; id_rt = '0; ex_wreg = '0; mem_wreg = '0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; id_branch = 1'b0;
        id_mdu = 1'b0; branch_taken = 1'b0;
        ex_RegWrite = 1'b0; ex_MemRead = 1'b0;
        mem_RegWrite = 1'b0; mem_MemRead = 1'b0;
        mdu_start = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // lw $1 in EX, ID instruction reads $1 through rs
    task automatic load_use();
        ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_wreg = 5'd1;
        id_rs = 5'd1; id_rs_used = 1'b1;
    endtask

    initial begin
        // ---------------- reset: all outputs held at zero ----------------
        clr();
        load_use();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_outs1", 32'(outs1()), 32'(c_NONE));
        chk("rst_outs2", 32'(outs2()), 32'(c_NONE));
        chk("rst_busy", 32'(u_if1.mdu_busy), 32'd0);
        chk("rst_cnt", 32'(u_if1.stall_count), 32'd0);
        rst = 1'b0;
        clr();
        #1;
        chk("idle_outs", 32'(outs1()), 32'(c_NONE));

        // ---------------- load-use interlock ----------------
        load_use();
        #1;
        chk("lu_db", 32'(outs1()), 32'(c_DB));
        tick();
        clr();
        #1;
        chk("lu_release", 32'(outs1()), 32'(c_NONE));
        chk("lu_cnt", 32'(u_if1.stall_count), 32'd1);
        ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_wreg = 5'd0;
        id_rs = 5'd1; id_rs_used = 1'b1;
        #1;
        chk("lu_nomatch", 32'(outs1()), 32'(c_NONE));
        id_rs = 5'd0;
        #1;
        chk("lu_reg0", 32'(outs1()), 32'(c_NONE));
        tick();
        clr();

        // ---------------- branch operand interlocks ----------------
        id_branch = 1'b1; id_rs = 5'd3; id_rs_used = 1'b1;
        ex_RegWrite = 1'b1; ex_wreg = 5'd3; branch_taken = 1'b1;
        #1;
        chk("br_ex_db", 32'(outs1()), 32'(c_DB));
        tick();
        ex_RegWrite = 1'b0; ex_wreg = 5'd0;
        mem_MemRead = 1'b1; mem_RegWrite = 1'b1; mem_wreg = 5'd3;
        #1;
        chk("br_mem_db", 32'(outs1()), 32'(c_DB));
        tick();
        mem_MemRead = 1'b0; mem_RegWrite = 1'b0; mem_wreg = 5'd0;
        #1;
        chk("br_flush", 32'(outs1()), 32'(c_BR));
        chk("br_dslot", 32'(outs2()), 32'(c_NONE));
        chk("br_cnt1", 32'(u_if1.stall_count), 32'd3);
        chk("br_cnt2", 32'(u_if2.stall_count), 32'd3);
        tick();
        clr();

        // ---------------- MDU busy countdown ----------------
        mdu_start = 1'b1;
        #1;
        chk("mdu_pre", 32'(u_if1.mdu_busy), 32'd0);
        tick();
        mdu_start = 1'b0;
        id_mdu = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk($sformatf("mdu_busy%0d", i), 32'(u_if1.mdu_busy), 32'd1);
            chk($sformatf("mdu_done%0d", i), 32'(u_if1.mdu_done), 32'(i == 8));
            chk($sformatf("mdu_db%0d", i), 32'(outs1()), 32'(c_DB));
            tick();
        end
        #1;
        chk("mdu_idle", 32'(u_if1.mdu_busy), 32'd0);
        chk("mdu_release", 32'(outs1()), 32'(c_NONE));
        chk("mdu_cnt", 32'(u_if1.stall_count), 32'd11);
        tick();
        clr();

        // ---------------- short memory freeze over a load-use ----------------
        dmem_req = 1'b1; dmem_ready = 1'b0;
        load_use();
        mdu_start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("fz_outs%0d", i), 32'(outs1()), 32'(c_FZ));
            chk($sformatf("fz_err%0d", i), 32'(u_if1.mem_err), 32'd0);
            chk($sformatf("fz_mdu%0d", i), 32'(u_if1.mdu_busy), 32'(i > 1));
            tick();
            mdu_start = 1'b0;
        end
        dmem_ready = 1'b1;
        #1;
        chk("fz_then_db", 32'(outs1()), 32'(c_DB));
        tick();
        clr();
        #1;
        chk("fz_clear", 32'(outs1()), 32'(c_NONE));
        chk("fz_cnt", 32'(u_if1.stall_count), 32'd15);
        repeat (10) tick();
        chk("fz_mdu_end", 32'(u_if1.mdu_busy), 32'd0);

        // ---------------- memory timeout ----------------
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            #1;
            chk($sformatf("to_fz%0d", i), 32'(outs1()), 32'(c_FZ));
            chk($sformatf("to_err%0d", i), 32'(u_if1.mem_err), 32'd0);
            tick();
        end
        #1;
        chk("to_err_outs", 32'(outs1()), 32'(c_ERR));
        chk("to_err_pulse", 32'(u_if1.mem_err), 32'd1);
        tick();
        dmem_req = 1'b0;
        #1;
        chk("to_run", 32'(outs1()), 32'(c_NONE));
        chk("to_err_gone", 32'(u_if1.mem_err), 32'd0);
        chk("to_cnt", 32'(u_if1.stall_count), 32'd31);
        tick();
        clr();

        // ---------------- reset during MDU BUSY and memory WAIT ----------------
        mdu_start = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        #1;
        chk("mr_fz", 32'(outs1()), 32'(c_FZ));
        tick();
        mdu_start = 1'b0;
        #1;
        chk("mr_busy", 32'(u_if1.mdu_busy), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("mr_rst_outs1", 32'(outs1()), 32'(c_NONE));
        chk("mr_rst_outs2", 32'(outs2()), 32'(c_NONE));
        chk("mr_rst_busy", 32'(u_if1.mdu_busy), 32'd0);
        chk("mr_rst_cnt", 32'(u_if1.stall_count), 32'd0);
        tick();
        rst = 1'b0;
        clr();
        #1;
        chk("mr_after_busy", 32'(u_if1.mdu_busy), 32'd0);
        chk("mr_after_outs", 32'(outs1()), 32'(c_NONE));
        chk("mr_after_cnt", 32'(u_if1.stall_count), 32'd0);

        // ---------------- counter saturation ----------------
        load_use();
        repeat (300) tick();
        clr();
        #1;
        chk("sat_cnt8", 32'(u_if2.stall_count), 32'd255);
        chk("sat_cnt16", 32'(u_if1.stall_count), 32'd300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
